// File: rtl/bpb_pkg.sv
// rtl/bpb_pkg.sv - shared types and helpers for the parametrised branch prediction buffer
// Contents: FSM state enum, INIT_VAL computation, saturating counter step.
package bpb_pkg;

    typedef enum logic {
        BPB_INIT = 1'b0,
        BPB_RUN  = 1'b1
    } bpb_state_e;

    // Weak-not-taken starting value for a counter of the given width.
    function automatic int unsigned init_val(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 1)) - 32'd1;
    endfunction

    // One saturating step; the bound is checked before the step so the
    // counter never wraps. Counters up to 4 bits are carried in 4 bits.
    function automatic logic [3:0] sat_step(input logic [3:0] ctr,
                                            input logic dir,
                                            input int unsigned width);
        logic [3:0] max_v;
        max_v = 4'((32'd1 << width) - 32'd1);
        if (dir) begin
            return (ctr >= max_v) ? max_v : ctr + 4'd1;
        end
        return (ctr == 4'd0) ? 4'd0 : ctr - 4'd1;
    endfunction

endpackage

// File: rtl/bpb_bank.sv
// rtl/bpb_bank.sv - one way of counters: SETS x CTR_BITS storage
// Ports: clock; rd_addr/rd_taken read port (combinational, pre-update value);
//        upd_en/upd_addr/upd_dir saturating update; init_en/init_addr sweep write.
module bpb_bank
    import bpb_pkg::*;
#(
    parameter  int SETS      = 128,
    parameter  int CTR_BITS  = 2,
    localparam int ADDR_BITS = $clog2(SETS)
) (
    input  logic                 clock,
    input  logic [ADDR_BITS-1:0] rd_addr,
    output logic                 rd_taken,
    input  logic                 upd_en,
    input  logic [ADDR_BITS-1:0] upd_addr,
    input  logic                 upd_dir,
    input  logic                 init_en,
    input  logic [ADDR_BITS-1:0] init_addr
);

    localparam logic [CTR_BITS-1:0] INIT_VAL = CTR_BITS'(init_val(CTR_BITS));
    localparam logic [CTR_BITS-1:0] TAKEN_TH = CTR_BITS'(32'd1 << (CTR_BITS - 1));

    logic [CTR_BITS-1:0] mem_q [SETS];
    logic [CTR_BITS-1:0] mem_d [SETS];

    // Contents need no reset: the top-level sweep rewrites every set.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_comb begin
        mem_d = mem_q;
        if (init_en) begin
            mem_d[init_addr] = INIT_VAL;
        end else if (upd_en) begin
            mem_d[upd_addr] = CTR_BITS'(sat_step(4'(mem_q[upd_addr]), upd_dir, CTR_BITS));
        end
    end

    assign rd_taken = (mem_q[rd_addr] >= TAKEN_TH);

endmodule

// File: rtl/bpb_param.sv
// rtl/bpb_param.sv - parametrised per-way saturating-counter branch prediction buffer
// Ports: clock, reset (sync, active high); stall holds lookup outputs;
//        inst_addr lookup index; update/branch_result/buffer_addr/buffer_offset
//        resolution write-back; prediction, lookup_index registered outputs;
//        ready high once the initialisation sweep finishes.
// Optional: BPB_GSHARE_EN adds a global history register XORed into the lookup index.
module bpb_param
    import bpb_pkg::*;
#(
    parameter  int SETS      = 128,
    parameter  int WAYS      = 4,
    parameter  int CTR_BITS  = 2,
    localparam int ADDR_BITS = $clog2(SETS),
    localparam int OFF_BITS  = $clog2(WAYS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 stall,
    input  logic [ADDR_BITS-1:0] inst_addr,
    input  logic                 update,
    input  logic                 branch_result,
    input  logic [ADDR_BITS-1:0] buffer_addr,
    input  logic [OFF_BITS-1:0]  buffer_offset,
    output logic [WAYS-1:0]      prediction,
    output logic [ADDR_BITS-1:0] lookup_index,
    output logic                 ready
);

    bpb_state_e           state_q, state_d;
    logic [ADDR_BITS-1:0] ptr_q, ptr_d;
    logic [WAYS-1:0]      pred_q, pred_d;
    logic [ADDR_BITS-1:0] lidx_q, lidx_d;
    logic                 ready_q, ready_d;

    logic [ADDR_BITS-1:0] idx;
    logic [WAYS-1:0]      rd_taken;
    logic [WAYS-1:0]      upd_en_vec;
    logic                 init_en;

`ifdef BPB_GSHARE_EN
    logic [ADDR_BITS-1:0] ghr_q, ghr_d;

    // History shifts in resolved outcomes only while running.
    always_comb begin
        ghr_d = ghr_q;
        if (state_q == BPB_RUN && update) begin
            ghr_d = ADDR_BITS'({ghr_q, branch_result});
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign idx = inst_addr ^ ghr_q;
`else
    assign idx = inst_addr;
`endif

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= BPB_INIT;
            ptr_q   <= '0;
            pred_q  <= '0;
            lidx_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            pred_q  <= pred_d;
            lidx_q  <= lidx_d;
            ready_q <= ready_d;
        end
    end

    // Next state: sweep one set per cycle, leave INIT after the last set.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == BPB_INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == ADDR_BITS'(SETS - 1)) begin
                state_d = BPB_RUN;
            end
        end
    end

    // Outputs: ready rises together with the move to RUN; bank reads see
    // pre-update contents, so a same-cycle update shows up on the next lookup.
    always_comb begin
        pred_d     = pred_q;
        lidx_d     = lidx_q;
        ready_d    = (state_d == BPB_RUN);
        init_en    = (state_q == BPB_INIT);
        upd_en_vec = '0;
        if (state_q == BPB_RUN) begin
            if (!stall) begin
                pred_d = rd_taken;
                lidx_d = idx;
            end
            if (update) begin
                upd_en_vec[buffer_offset] = 1'b1;
            end
        end
    end

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        bpb_bank #(
            .SETS     (SETS),
            .CTR_BITS (CTR_BITS)
        ) u_bank (
            .clock     (clock),
            .rd_addr   (idx),
            .rd_taken  (rd_taken[w]),
            .upd_en    (upd_en_vec[w]),
            .upd_addr  (buffer_addr),
            .upd_dir   (branch_result),
            .init_en   (init_en),
            .init_addr (ptr_q)
        );
    end

    assign prediction   = pred_q;
    assign lookup_index = lidx_q;
    assign ready        = ready_q;

endmodule

// File: tb/tb_bpb_param.sv
// tb/tb_bpb_param.sv - self-checking bench for bpb_param against a counter-array model
module tb_bpb_param;

    localparam int SETS  = 8;
    localparam int WAYS  = 4;
    localparam int CTR   = 2;
    localparam int AB    = $clog2(SETS);
    localparam int OB    = $clog2(WAYS);
    localparam int CMAX  = (1 << CTR) - 1;
    localparam int CINIT = (1 << (CTR - 1)) - 1;
    localparam int CTH   = 1 << (CTR - 1);

    logic          clock;
    logic          reset;
    logic          stall;
    logic [AB-1:0] inst_addr;
    logic          update;
    logic          branch_result;
    logic [AB-1:0] buffer_addr;
    logic [OB-1:0] buffer_offset;
    logic [WAYS-1:0] prediction;
    logic [AB-1:0] lookup_index;
    logic          ready;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int            m_ctr [SETS][WAYS];
    int            m_sweep;
    int            m_ghr;
    logic [WAYS-1:0] m_pred;
    logic [AB-1:0] m_idx;
    logic          m_ready;

    bpb_param #(.SETS(SETS), .WAYS(WAYS), .CTR_BITS(CTR)) dut (
        .clock         (clock),
        .reset         (reset),
        .stall         (stall),
        .inst_addr     (inst_addr),
        .update        (update),
        .branch_result (branch_result),
        .buffer_addr   (buffer_addr),
        .buffer_offset (buffer_offset),
        .prediction    (prediction),
        .lookup_index  (lookup_index),
        .ready         (ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic model_edge();
        int ix;
        if (reset) begin
            m_sweep = SETS;
            m_pred  = '0;
            m_idx   = '0;
            m_ready = 1'b0;
            m_ghr   = 0;
            for (int s = 0; s < SETS; s++)
                for (int w = 0; w < WAYS; w++)
                    m_ctr[s][w] = CINIT;
        end else if (m_sweep > 0) begin
            m_sweep = m_sweep - 1;
            m_ready = (m_sweep == 0);
        end else begin
`ifdef BPB_GSHARE_EN
            ix = int'(inst_addr) ^ m_ghr;
`else
            ix = int'(inst_addr);
`endif
            if (!stall) begin
                for (int w = 0; w < WAYS; w++) m_pred[w] = (m_ctr[ix][w] >= CTH);
                m_idx = AB'(ix);
            end
            if (update) begin
                if (branch_result)
                    m_ctr[buffer_addr][buffer_offset] = (m_ctr[buffer_addr][buffer_offset] + 1 > CMAX) ? CMAX : m_ctr[buffer_addr][buffer_offset] + 1;
                else
                    m_ctr[buffer_addr][buffer_offset] = (m_ctr[buffer_addr][buffer_offset] - 1 < 0) ? 0 : m_ctr[buffer_addr][buffer_offset] - 1;
                m_ghr = (m_ghr * 2 + int'(branch_result)) % SETS;
            end
        end
    endtask

    task automatic check(input string tag);
        total++;
        assert (ready === m_ready) else begin
            bad++;
            $error("FAIL %s ready got=%0b exp=%0b", tag, ready, m_ready);
        end
        total++;
        assert (prediction === m_pred) else begin
            bad++;
            $error("FAIL %s prediction got=%b exp=%b", tag, prediction, m_pred);
        end
        total++;
        assert (lookup_index === m_idx) else begin
            bad++;
            $error("FAIL %s lookup_index got=%0d exp=%0d", tag, lookup_index, m_idx);
        end
    endtask

    // Directed constant check for the plain (non-gshare) index mapping.
    task automatic dchk(input string tag, input logic [31:0] got, input logic [31:0] exp);
`ifndef BPB_GSHARE_EN
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
`endif
    endtask

    task automatic tick(input string tag);
        @(posedge clock);
        model_edge();
        @(negedge clock);
        check(tag);
    endtask

    task automatic drive(input logic st, input logic up, input logic br,
                         input int ba, input int bo, input int ia);
        stall         = st;
        update        = up;
        branch_result = br;
        buffer_addr   = AB'(ba);
        buffer_offset = OB'(bo);
        inst_addr     = AB'(ia);
    endtask

    task automatic sweep_and_count(input string tag);
        int cnt;
        cnt = 0;
        while (ready !== 1'b1 && cnt < 100) begin
            tick(tag);
            cnt++;
        end
        total++;
        assert (cnt == SETS) else begin
            bad++;
            $error("FAIL %s ready_low_cycles got=%0d exp=%0d", tag, cnt, SETS);
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        // Init sweep with a spurious update pulse that must be ignored
        tick("reset0");
        tick("reset1");
        dchk("reset_pred", 32'(prediction), 0);
        dchk("reset_ready", 32'(ready), 0);
        reset = 1'b0;
        drive(1, 1, 1, 2, 1, 5);
        sweep_and_count("init_sweep");
        drive(0, 0, 0, 0, 0, 0);
        for (int a = 0; a < SETS; a++) begin
            inst_addr = AB'(a);
            tick("init_vals");
            dchk("init_pred", 32'(prediction), 0);
        end

        // Training: addr 2, way 1
        drive(0, 1, 1, 2, 1, 2);
        tick("train_t1");
        tick("train_t2");
        update = 1'b0;
        tick("train_look");
        dchk("train_taken", 32'(prediction), 32'h2);
        update = 1'b1;
        tick("train_t3");
        branch_result = 1'b0;
        tick("train_nt1");
        update = 1'b0;
        tick("train_look2");
        dchk("train_still", 32'(prediction), 32'h2);
        drive(0, 1, 0, 2, 1, 2);
        tick("train_nt2");
        update = 1'b0;
        tick("train_look3");
        dchk("train_back", 32'(prediction), 32'h0);

        // Low saturation: addr 0, way 3
        drive(0, 1, 0, 0, 3, 0);
        for (int i = 0; i < 3; i++) tick("lowsat_nt");
        branch_result = 1'b1;
        tick("lowsat_t1");
        update = 1'b0;
        tick("lowsat_look1");
        dchk("lowsat_p1", 32'(prediction[3]), 0);
        update = 1'b1;
        tick("lowsat_t2");
        update = 1'b0;
        tick("lowsat_look2");
        dchk("lowsat_p2", 32'(prediction[3]), 1);

        // Stall hold: lookup addr 3 while training way 2 under stall
        drive(0, 0, 0, 0, 0, 3);
        tick("stall_pre");
        drive(1, 1, 1, 3, 2, 6);
        tick("stall_hold");
        dchk("stall_pred", 32'(prediction), 0);
        dchk("stall_idx", 32'(lookup_index), 3);
        drive(0, 0, 0, 0, 0, 3);
        tick("stall_rel");
        dchk("stall_new", 32'(prediction), 32'h4);

        // Same-cycle lookup and update of addr 1, way 0
        drive(0, 1, 1, 1, 0, 1);
        tick("coll_same");
        dchk("coll_old", 32'(prediction[0]), 0);
        update = 1'b0;
        tick("coll_next");
        dchk("coll_new", 32'(prediction[0]), 1);

        // Reset in RUN, then a reset mid-sweep restarts the sweep
        reset = 1'b1;
        tick("rrun_rst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) tick("rrun_part");
        reset = 1'b1;
        tick("rrun_rst2");
        reset = 1'b0;
        sweep_and_count("rrun_sweep");
        for (int a = 0; a < SETS; a++) begin
            inst_addr = AB'(a);
            tick("rrun_vals");
            dchk("rrun_pred", 32'(prediction), 0);
        end

`ifdef BPB_GSHARE_EN
        // History T,T,NT -> 3'b110; lookup 3'b011 maps to 3'b101
        drive(0, 1, 1, 4, 0, 0);
        tick("gs_t1");
        tick("gs_t2");
        branch_result = 1'b0;
        tick("gs_nt");
        drive(0, 0, 0, 0, 0, 3);
        tick("gs_look");
        total++;
        assert (lookup_index === 3'b101) else begin
            bad++;
            $error("FAIL gs_index got=%b exp=101", lookup_index);
        end
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            reset         = ($urandom_range(0, 99) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            update        = $urandom_range(0, 1) == 1;
            branch_result = $urandom_range(0, 2) != 0;
            buffer_addr   = AB'($urandom_range(0, SETS - 1));
            buffer_offset = OB'($urandom_range(0, WAYS - 1));
            inst_addr     = AB'($urandom_range(0, SETS - 1));
            tick("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
